// File: rtl/console_uart_tx.sv
// Console UART transmitter: snoops core data-memory writes to a console byte
// port and a halt port, queues console bytes in a FIFO and shifts them out 8N1.
package memory_io_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  do_write;
        logic [31:0] data;
    } memory_io_req;
endpackage

// state | meaning
// IDLE  | line high; pops the next byte as soon as the FIFO is non-empty
// START | start bit, line low for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit, line high for one bit time
module console_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0002_FFF8,
    parameter logic [31:0] HALT_ADDR    = 32'h0002_FFFC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  memory_io_pkg::memory_io_req data_mem_req,
    output logic                       uart_tx,
    output logic                       busy,
    output logic                       overflow,
    output logic                       halt
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    tx_state_e        state, state_d;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full;
    logic             console_wr, halt_wr, push, pop;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shift_reg, shift_reg_d;
    logic             tx_d;
    logic             halt_pending;
    logic             unused_data_hi;

    assign console_wr = data_mem_req.valid && (data_mem_req.addr == CONSOLE_ADDR)
                        && (data_mem_req.do_write != 4'b0);
    assign halt_wr    = data_mem_req.valid && (data_mem_req.addr == HALT_ADDR)
                        && (data_mem_req.do_write != 4'b0);
    assign unused_data_hi = ^data_mem_req.data[31:8];

    // Extra pointer bit separates full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W])
                        && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push       = console_wr && (!fifo_full || pop);
    assign busy       = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= data_mem_req.data[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
            halt_pending <= 1'b0;
            halt         <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            end
            if (console_wr && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (halt_wr) begin
                halt_pending <= 1'b1;
            end
            if (halt_pending && fifo_empty && (state == IDLE)) begin
                halt <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
        end else begin
            state     <= state_d;
            baud_cnt  <= baud_cnt_d;
            bit_idx   <= bit_idx_d;
            shift_reg <= shift_reg_d;
            uart_tx   <= tx_d;
        end
    end

    // tx_d is the line level for the state being entered, so uart_tx is a flop.
    always_comb begin
        state_d     = state;
        baud_cnt_d  = baud_cnt;
        bit_idx_d   = bit_idx;
        shift_reg_d = shift_reg;
        tx_d        = uart_tx;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_reg_d = fifo_mem[rd_ptr[PTR_W-1:0]];
                    baud_cnt_d  = BAUD_LOAD;
                    tx_d        = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    baud_cnt_d = BAUD_LOAD;
                    bit_idx_d  = '0;
                    tx_d       = shift_reg[0];
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt - CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_cnt_d = BAUD_LOAD;
                    bit_idx_d  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_reg_d = {1'b0, shift_reg[7:1]};
                        tx_d        = shift_reg[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt - CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: directed and randomized write traffic checked
// against a queue-based timing model of the console FIFO and 8N1 line.
module tb_console_uart_tx;
    import memory_io_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int NS    = 10 * CPB;
    localparam int FRAME = 10 * CPB + 1;
    localparam logic [31:0] CONSOLE_ADDR = 32'h0002_FFF8;
    localparam logic [31:0] HALT_ADDR    = 32'h0002_FFFC;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    memory_io_req req;
    logic         uart_tx, busy, overflow, halt;

    int cyc = 0;
    int halt_seen = -1;
    int vectors = 0;
    int miscompares = 0;

    int         wr_t[$];
    logic [7:0] wr_b[$];
    bit         wr_halt[$];
    logic [7:0] exp_b[$];
    int         exp_t[$];
    int         exp_ovf;
    int         exp_halt;

    console_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH),
        .CONSOLE_ADDR(CONSOLE_ADDR),
        .HALT_ADDR(HALT_ADDR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_mem_req(req),
        .uart_tx(uart_tx),
        .busy(busy),
        .overflow(overflow),
        .halt(halt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        if (reset) halt_seen = -1;
        else if (halt === 1'b1 && halt_seen < 0) halt_seen = cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic memory_io_req mk(input logic v, input logic [31:0] a,
                                        input logic [3:0] be, input logic [31:0] d);
        memory_io_req r;
        r.valid = v;
        r.addr = a;
        r.do_write = be;
        r.data = d;
        return r;
    endfunction

    // Ideal line waveform of one frame, one sample per clock.
    function automatic logic [NS-1:0] frame_wave(input logic [7:0] b);
        logic [NS-1:0] w;
        for (int i = 0; i < NS; i++) begin
            if (i < CPB) w[i] = 1'b0;
            else if (i < 9 * CPB) w[i] = b[3'((i - CPB) / CPB)];
            else w[i] = 1'b1;
        end
        return w;
    endfunction

    task automatic clr_wr();
        wr_t.delete();
        wr_b.delete();
        wr_halt.delete();
    endtask

    task automatic add_wr(input int t, input logic [7:0] b, input bit h);
        wr_t.push_back(t);
        wr_b.push_back(b);
        wr_halt.push_back(h);
    endtask

    // A byte leaves the FIFO one edge after it arrives, but no sooner than
    // one frame period after the previous departure; a write finding DEPTH
    // bytes still waiting is dropped.
    function automatic void run_model(input int base);
        logic [7:0] q_b[$];
        int q_t[$];
        int next_ok, last_pop, h, p, t;
        exp_b.delete();
        exp_t.delete();
        exp_ovf = -1;
        exp_halt = -1;
        next_ok = 0;
        last_pop = -FRAME;
        h = -1;
        for (int k = 0; k <= wr_t.size(); k++) begin
            t = (k < wr_t.size()) ? base + wr_t[k] : 1_000_000_000;
            while (q_b.size() > 0) begin
                p = (q_t[0] + 1 > next_ok) ? q_t[0] + 1 : next_ok;
                if (p > t) break;
                exp_b.push_back(q_b.pop_front());
                void'(q_t.pop_front());
                exp_t.push_back(p);
                next_ok = p + FRAME;
                last_pop = p;
            end
            if (k < wr_t.size()) begin
                if (wr_halt[k]) begin
                    if (h < 0) h = t;
                end else if (q_b.size() < DEPTH) begin
                    q_b.push_back(wr_b[k]);
                    q_t.push_back(t);
                end else if (exp_ovf < 0) begin
                    exp_ovf = t;
                end
            end
        end
        if (h >= 0) exp_halt = (h + 1 > last_pop + FRAME) ? h + 1 : last_pop + FRAME;
    endfunction

    task automatic drive_writes(input int base, input bit check_ovf);
        for (int k = 0; k < wr_t.size(); k++) begin
            while (cyc < base + wr_t[k] - 1) tick();
            req = mk(1'b1, wr_halt[k] ? HALT_ADDR : CONSOLE_ADDR,
                     4'($urandom_range(1, 15)), {24'($urandom), wr_b[k]});
            tick();
            req = '0;
            if (check_ovf) chk("overflow_after_write", overflow, (exp_ovf >= 0 && cyc >= exp_ovf));
        end
    endtask

    task automatic rx_frame(input int budget, output logic [NS-1:0] wave,
                            output logic [NS-1:0] bsy, output int t0, output bit ok);
        ok = 1'b0;
        t0 = -1;
        wave = '1;
        bsy = '0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            if (uart_tx === 1'b0) ok = 1'b1;
        end
        if (ok) begin
            t0 = cyc;
            wave[0] = uart_tx;
            bsy[0] = busy;
            for (int i = 1; i < NS; i++) begin
                tick();
                wave[i] = uart_tx;
                bsy[i] = busy;
            end
        end
    endtask

    task automatic receive_all(input string tag);
        logic [NS-1:0] wave, bsy, ones;
        int t0;
        bit ok;
        ones = '1;
        for (int k = 0; k < exp_b.size(); k++) begin
            rx_frame(4 * FRAME, wave, bsy, t0, ok);
            chk({tag, "_frame_found"}, ok, 1'b1);
            chk({tag, "_frame_start"}, t0, exp_t[k]);
            chk({tag, "_frame_bits"}, wave, frame_wave(exp_b[k]));
            chk({tag, "_frame_busy"}, bsy, ones);
        end
    endtask

    task automatic run_traffic(input string tag);
        logic [NS-1:0] wave, bsy;
        int t0, base;
        bit ok;
        base = cyc;
        run_model(base);
        fork
            drive_writes(base, 1'b1);
            receive_all(tag);
        join
        tick();
        chk({tag, "_idle_busy"}, busy, 1'b0);
        rx_frame(3 * FRAME, wave, bsy, t0, ok);
        chk({tag, "_no_extra_frame"}, ok, 1'b0);
        chk({tag, "_overflow_final"}, overflow, exp_ovf >= 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [NS-1:0] wave, bsy, w;
        int t0, base, t;
        bit ok;
        req = '0;
        #2 reset = 1'b1;
        #1;
        chk("reset_uart_tx", uart_tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        chk("reset_halt", halt, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_uart_tx", uart_tx, 1'b1);
        chk("idle_busy", busy, 1'b0);

        clr_wr();
        add_wr(1, 8'h41, 1'b0);
        run_traffic("single_A");

        clr_wr();
        add_wr(1, 8'h48, 1'b0);
        add_wr(2, 8'h69, 1'b0);
        add_wr(3, 8'h0A, 1'b0);
        run_traffic("hi_newline");

        req = mk(1'b1, CONSOLE_ADDR, 4'h0, 32'h0000_0041);
        tick();
        chk("nowrite_busy", busy, 1'b0);
        req = mk(1'b1, 32'h0002_FFF4, 4'hF, 32'h0000_0042);
        tick();
        chk("otheraddr_busy", busy, 1'b0);
        req = mk(1'b0, CONSOLE_ADDR, 4'hF, 32'h0000_0043);
        tick();
        chk("novalid_busy", busy, 1'b0);
        req = mk(1'b1, HALT_ADDR, 4'h0, 32'h0);
        tick();
        req = '0;
        rx_frame(3 * FRAME, wave, bsy, t0, ok);
        chk("ignored_no_frame", ok, 1'b0);
        chk("ignored_busy", busy, 1'b0);
        chk("ignored_halt", halt, 1'b0);

        clr_wr();
        t = 0;
        for (int k = 0; k < 20; k++) begin
            t += ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 90)) : 1;
            add_wr(t, 8'($urandom), 1'b0);
        end
        run_traffic("random");
        do_reset();

        clr_wr();
        for (int k = 0; k < 10; k++) add_wr(k + 1, 8'($urandom), 1'b0);
        run_traffic("burst_overflow");

        // Reset in the middle of a frame with bytes still queued.
        clr_wr();
        add_wr(1, 8'h00, 1'b0);
        add_wr(2, 8'hA5, 1'b0);
        add_wr(3, 8'h3C, 1'b0);
        add_wr(4, 8'hFF, 1'b0);
        base = cyc;
        run_model(base);
        drive_writes(base, 1'b0);
        while (cyc < exp_t[0] + CPB + 2) tick();
        w = frame_wave(exp_b[0]);
        chk("abort_pre_tx", uart_tx, w[cyc - exp_t[0]]);
        chk("abort_pre_busy", busy, 1'b1);
        chk("abort_pre_overflow", overflow, 1'b1);
        #3 reset = 1'b1;
        #1;
        chk("abort_uart_tx", uart_tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_overflow", overflow, 1'b0);
        chk("abort_halt", halt, 1'b0);
        req = mk(1'b1, CONSOLE_ADDR, 4'hF, 32'h0000_0055);
        tick();
        tick();
        chk("inreset_busy", busy, 1'b0);
        reset = 1'b0;
        req = '0;
        rx_frame(3 * FRAME, wave, bsy, t0, ok);
        chk("abort_no_frame", ok, 1'b0);
        chk("abort_busy_after", busy, 1'b0);

        clr_wr();
        add_wr(1, 8'h4F, 1'b0);
        add_wr(2, 8'h4B, 1'b0);
        add_wr(3, 8'h21, 1'b0);
        add_wr(4, 8'h00, 1'b1);
        add_wr(5, 8'h3F, 1'b0);
        run_traffic("halt_drain");
        chk("halt_rise_cycle", halt_seen, exp_halt);
        repeat (5) tick();
        chk("halt_sticky", halt, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
